regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port successor to the single-port synchronous register file: one write port and two independent read ports, with write-to-read bypass, registered read data and valid flags, out-of-range address detection, and a hardware clear sequencer that zeroes the array after reset or on request. It sits between datapath stages that need two operands per cycle and one result write-back per cycle.

## Interface
- ADR, 3, address width for all ports
- DAT, 8, data word width
- DPTH, 8, number of entries; must satisfy 1 ≤ DPTH ≤ 2**ADR
- Clk  input  1  clock; all state changes on rising edge
- Rst_n  input  1  reset; asynchronous, active-low
- CS  input  1  chip select; gates every write and read request
- WE  input  1  write enable
- WAddr  input  ADR  write address
- WData  input  DAT  write data
- RE0, RE1  input  1 each  read enable, port 0 / port 1
- RAddr0, RAddr1  input  ADR each  read address, port 0 / port 1
- RData0, RData1  output  DAT each  registered read data
- RValid0, RValid1  output  1 each  read data valid, one-cycle pulse
- Clr  input  1  clear request, sampled in IDLE only
- Busy  output  1  high while the clear sequence runs
- AddrErr  output  1  one-cycle pulse: an accepted request used an address ≥ DPTH

## Operation
- States: CLEAR, IDLE. Reset forces CLEAR with the clear index at 0.
- CLEAR: each edge writes 0 to entry[idx], idx++. On the edge that writes entry DPTH-1, go to IDLE. Busy=1. WE, RE0, RE1 and Clr are ignored. RValid and AddrErr stay 0.
- IDLE, write: when CS&WE and WAddr<DPTH, entry[WAddr]←WData at the edge. When WAddr≥DPTH, the write is dropped and AddrErr=1 next cycle.
- IDLE, read on port n: when CS&REn, on the next cycle RDatan = entry[RAddrn] and RValidn=1.
  - If RAddrn≥DPTH: RDatan=0, RValidn=1, AddrErr=1.
  - Bypass: if a write to the same in-range address is accepted in the same cycle, RDatan returns WData (write-first).
  - Both ports may read the same address in the same cycle.
- With no read on port n, RValidn=0 and RDatan holds its last value.
- Clr=1 in IDLE: any write in the same cycle still executes; the next state is CLEAR and the clear overwrites the whole array.
- AddrErr is the OR over all three ports for that cycle.

## Timing
- Reset values: RData0=RData1=0, RValid0=RValid1=0, AddrErr=0, Busy=1, state=CLEAR, idx=0.
- Rst_n asserted mid-operation (during CLEAR or IDLE): the sequence restarts from idx 0 immediately. Array contents are undefined until the clear completes.
- Clear duration: Busy stays high for exactly DPTH rising edges after Rst_n deasserts, or after the edge that samples Clr. The first request accepted is at the edge where Busy is already 0.
- Read latency: 1 cycle, request edge to RData/RValid.
- Write visibility:
  - Same-cycle read sees the new data through the bypass.
  - A read one cycle later sees the new data from the array.
- idx width is clog2(DPTH), with a minimum of 1. idx never exceeds DPTH-1, including when DPTH is not a power of two.

## Structure
- Package regfile_pkg holds:
  - state enum (ST_IDLE, ST_CLEAR)
  - clog2 helper function
  - parameter legality check
- Sub-module regfile_rdport, instantiated twice. It contains:
  - address range check
  - bypass compare and mux
  - output RData/RValid registers with async reset
- The top level holds the array, write decode, clear FSM/counter and the AddrErr OR.

## Test plan
- Reset release, DPTH=8: Busy high for 8 edges, then 0. Reads of all addresses return 0 with RValid=1.
- Write 0xA5 to address 3, then read port 0 at address 3 next cycle → RData0=0xA5 one cycle later, RValid0=1 for one cycle.
- Same cycle: write 0x5A to address 2, read port 0 and port 1 both at address 2 (old value 0x11) → both return 0x5A (bypass).
- DPTH=6, ADR=3: write to address 7 and read port 1 at address 6 → array unchanged, RData1=0, AddrErr=1 for one cycle.
- Fill all entries with nonzero data, pulse Clr together with a write → Busy high for DPTH cycles, requests during CLEAR are ignored, afterwards all entries read 0.
- Assert Rst_n low for a partial cycle at clear index 4 → all outputs return to reset values immediately, and the clear restarts from 0 for a full DPTH cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and elaboration helpers for the multi-port register file.
// No logic here: state encoding, width helper and parameter legality check.
package regfile_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // Clear index needs at least one bit even for a single-entry array.
  function automatic int idx_width(input int dpth);
    return (clog2(dpth) < 1) ? 1 : clog2(dpth);
  endfunction

  function automatic bit params_ok(input int adr, input int dat, input int dpth);
    return (adr >= 1) && (dat >= 1) && (dpth >= 1) && (dpth <= (1 << adr));
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One read port: range check, write-first bypass, registered data/valid.
// Latency 1 cycle from accepted request; no backpressure, data holds when idle.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int ADR  = 3,
  parameter int DAT  = 8,
  parameter int DPTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req,
  input  logic [ADR-1:0] raddr,
  input  logic [DAT-1:0] arr_dat,
  input  logic           wr_vld,
  input  logic [ADR-1:0] waddr,
  input  logic [DAT-1:0] wdata,
  output logic [DAT-1:0] rdata,
  output logic           rvalid,
  output logic           err
);

  localparam logic [ADR:0] DPTH_W = (ADR+1)'(DPTH);

  logic           oor;
  logic           hit;
  logic [DAT-1:0] rdata_d, rdata_q;
  logic           rvalid_d, rvalid_q;

  assign oor = ({1'b0, raddr} >= DPTH_W);
  assign hit = wr_vld && (waddr == raddr);
  assign err = req && oor;

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = req;
    if (req) begin
      if (oor)      rdata_d = '0;
      else if (hit) rdata_d = wdata;
      else          rdata_d = arr_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule

// File: rtl/regfile_mp.sv
// 1W/2R register file with bypass, address-error pulse and a hardware clear sequencer.
// Reads return 1 cycle after request; while Busy every request is ignored (no stall signalling).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int ADR  = 3,
  parameter int DAT  = 8,
  parameter int DPTH = 8
) (
  input  logic           Clk,
  input  logic           Rst_n,
  input  logic           CS,
  input  logic           WE,
  input  logic [ADR-1:0] WAddr,
  input  logic [DAT-1:0] WData,
  input  logic           RE0,
  input  logic           RE1,
  input  logic [ADR-1:0] RAddr0,
  input  logic [ADR-1:0] RAddr1,
  output logic [DAT-1:0] RData0,
  output logic [DAT-1:0] RData1,
  output logic           RValid0,
  output logic           RValid1,
  input  logic           Clr,
  output logic           Busy,
  output logic           AddrErr
);

  localparam int            IW       = idx_width(DPTH);
  localparam logic [ADR:0]  DPTH_W   = (ADR+1)'(DPTH);
  localparam logic [IW-1:0] IDX_LAST = IW'(DPTH-1);

  if (!params_ok(ADR, DAT, DPTH)) begin : g_bad_params
    $error("regfile_mp: illegal ADR/DAT/DPTH combination");
  end

  state_t         state_d, state_q;
  logic [IW-1:0]  idx_d, idx_q;
  logic           addr_err_d, addr_err_q;
  logic [DAT-1:0] mem_d [DPTH];
  logic [DAT-1:0] mem_q [DPTH];

  logic           busy;
  logic           wr_req, wr_oor, wr_vld;
  logic           rd_req0, rd_req1;
  logic           rd_err0, rd_err1;
  logic [DAT-1:0] arr_dat0, arr_dat1;

  assign busy    = (state_q == ST_CLEAR);
  assign wr_req  = !busy && CS && WE;
  assign wr_oor  = ({1'b0, WAddr} >= DPTH_W);
  assign wr_vld  = wr_req && !wr_oor;
  assign rd_req0 = !busy && CS && RE0;
  assign rd_req1 = !busy && CS && RE1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_CLEAR: begin
        if (idx_q == IDX_LAST) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_IDLE: begin
        // A write accepted alongside Clr still lands; the clear then wipes it.
        if (Clr) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < DPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (busy && (idx_q == IW'(i)))           mem_d[i] = '0;
      else if (wr_vld && (WAddr == ADR'(i)))   mem_d[i] = WData;
    end
  end

  // Only in-range entries are decoded; out-of-range addresses read as 0 here.
  always_comb begin
    arr_dat0 = '0;
    arr_dat1 = '0;
    for (int i = 0; i < DPTH; i++) begin
      if (RAddr0 == ADR'(i)) arr_dat0 = mem_q[i];
      if (RAddr1 == ADR'(i)) arr_dat1 = mem_q[i];
    end
  end

  assign addr_err_d = (wr_req && wr_oor) || rd_err0 || rd_err1;

  always_ff @(posedge Clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= ST_CLEAR;
      idx_q      <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      addr_err_q <= addr_err_d;
    end
  end

  regfile_rdport #(.ADR(ADR), .DAT(DAT), .DPTH(DPTH)) u_rd0 (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .req     (rd_req0),
    .raddr   (RAddr0),
    .arr_dat (arr_dat0),
    .wr_vld  (wr_vld),
    .waddr   (WAddr),
    .wdata   (WData),
    .rdata   (RData0),
    .rvalid  (RValid0),
    .err     (rd_err0)
  );

  regfile_rdport #(.ADR(ADR), .DAT(DAT), .DPTH(DPTH)) u_rd1 (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .req     (rd_req1),
    .raddr   (RAddr1),
    .arr_dat (arr_dat1),
    .wr_vld  (wr_vld),
    .waddr   (WAddr),
    .wdata   (WData),
    .rdata   (RData1),
    .rvalid  (RValid1),
    .err     (rd_err1)
  );

  assign Busy    = busy;
  assign AddrErr = addr_err_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: DPTH=8 and DPTH=6 instances share stimulus; expected values are hand-computed.
module tb_regfile_mp;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       CS, WE, RE0, RE1, Clr;
  logic [2:0] WAddr, RAddr0, RAddr1;
  logic [7:0] WData;

  logic [7:0] rd0_8, rd1_8, rd0_6, rd1_6;
  logic       rv0_8, rv1_8, busy_8, err_8;
  logic       rv0_6, rv1_6, busy_6, err_6;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 Clk = ~Clk;

  regfile_mp #(.ADR(3), .DAT(8), .DPTH(8)) u8 (
    .Clk(Clk), .Rst_n(Rst_n), .CS(CS), .WE(WE), .WAddr(WAddr), .WData(WData),
    .RE0(RE0), .RE1(RE1), .RAddr0(RAddr0), .RAddr1(RAddr1),
    .RData0(rd0_8), .RData1(rd1_8), .RValid0(rv0_8), .RValid1(rv1_8),
    .Clr(Clr), .Busy(busy_8), .AddrErr(err_8)
  );

  regfile_mp #(.ADR(3), .DAT(8), .DPTH(6)) u6 (
    .Clk(Clk), .Rst_n(Rst_n), .CS(CS), .WE(WE), .WAddr(WAddr), .WData(WData),
    .RE0(RE0), .RE1(RE1), .RAddr0(RAddr0), .RAddr1(RAddr1),
    .RData0(rd0_6), .RData1(rd1_6), .RValid0(rv0_6), .RValid1(rv1_6),
    .Clr(Clr), .Busy(busy_6), .AddrErr(err_6)
  );

  typedef struct {
    logic       cs, we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       re0;
    logic [2:0] ra0;
    logic       re1;
    logic [2:0] ra1;
    logic [7:0] rd0;
    logic       rv0;
    logic [7:0] rd1;
    logic       rv1;
  } vec_t;

  vec_t tbl [11];

  function automatic vec_t mkv(input logic cs, input logic we, input logic [2:0] wa,
                               input logic [7:0] wd, input logic re0, input logic [2:0] ra0,
                               input logic re1, input logic [2:0] ra1, input logic [7:0] rd0,
                               input logic rv0, input logic [7:0] rd1, input logic rv1);
    vec_t v;
    v.cs = cs; v.we = we; v.wa = wa; v.wd = wd;
    v.re0 = re0; v.ra0 = ra0; v.re1 = re1; v.ra1 = ra1;
    v.rd0 = rd0; v.rv0 = rv0; v.rd1 = rd1; v.rv1 = rv1;
    return v;
  endfunction

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic cs, input logic we, input logic [2:0] wa, input logic [7:0] wd,
                       input logic re0, input logic [2:0] ra0, input logic re1, input logic [2:0] ra1);
    CS = cs; WE = we; WAddr = wa; WData = wd;
    RE0 = re0; RAddr0 = ra0; RE1 = re1; RAddr1 = ra1;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
    Clr = 1'b0;
  endtask

  // Counts edges until Busy drops (bounded); quiet flags any u8 output activity while clearing.
  task automatic wait_clear(input bit use6, output int t8, output int t6, output bit quiet);
    t8 = 0;
    t6 = 0;
    quiet = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (t8 == 0) begin
        if (rv0_8 || rv1_8 || err_8) quiet = 1'b0;
        if (!busy_8) t8 = n;
      end
      if (t6 == 0 && !busy_6) t6 = n;
      if (t8 != 0 && (t6 != 0 || !use6)) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  t8, t6;
    bit  quiet;

    tbl[0]  = mkv(1'b1, 1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0);
    tbl[1]  = mkv(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b0, 3'd0, 8'hA5, 1'b1, 8'h00, 1'b0);
    tbl[2]  = mkv(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 8'hA5, 1'b0, 8'h00, 1'b0);
    tbl[3]  = mkv(1'b1, 1'b1, 3'd2, 8'h11, 1'b0, 3'd0, 1'b0, 3'd0, 8'hA5, 1'b0, 8'h00, 1'b0);
    tbl[4]  = mkv(1'b1, 1'b1, 3'd2, 8'h5A, 1'b1, 3'd2, 1'b1, 3'd2, 8'h5A, 1'b1, 8'h5A, 1'b1);
    tbl[5]  = mkv(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b1, 3'd3, 8'h5A, 1'b1, 8'hA5, 1'b1);
    tbl[6]  = mkv(1'b1, 1'b1, 3'd5, 8'h77, 1'b1, 3'd5, 1'b1, 3'd4, 8'h77, 1'b1, 8'h00, 1'b1);
    tbl[7]  = mkv(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 3'd5, 8'h77, 1'b0, 8'h77, 1'b1);
    tbl[8]  = mkv(1'b1, 1'b1, 3'd7, 8'hC3, 1'b1, 3'd7, 1'b0, 3'd0, 8'hC3, 1'b1, 8'h77, 1'b0);
    tbl[9]  = mkv(1'b0, 1'b1, 3'd3, 8'hFF, 1'b1, 3'd3, 1'b1, 3'd2, 8'hC3, 1'b0, 8'h77, 1'b0);
    tbl[10] = mkv(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 3'd7, 8'hA5, 1'b1, 8'hC3, 1'b1);

    Rst_n = 1'b1;
    idle_in();
    #1 Rst_n = 1'b0;
    #2;
    chk1("rst_busy8", busy_8, 1'b1);
    chk1("rst_busy6", busy_6, 1'b1);
    chk8("rst_rd0", rd0_8, 8'h00);
    chk8("rst_rd1", rd1_8, 8'h00);
    chk1("rst_rv0", rv0_8, 1'b0);
    chk1("rst_rv1", rv1_8, 1'b0);
    chk1("rst_err", err_8, 1'b0);

    repeat (2) @(posedge Clk);
    #1;
    chk1("rst_hold_busy", busy_8, 1'b1);
    Rst_n = 1'b1;
    wait_clear(1'b1, t8, t6, quiet);
    chki("init_busy_len8", t8, 8);
    chki("init_busy_len6", t6, 6);

    for (int a = 0; a < 8; a++) begin
      drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'(a), 1'b1, 3'(7 - a));
      step();
      chk8($sformatf("init_rd0_a%0d", a), rd0_8, 8'h00);
      chk1($sformatf("init_rv0_a%0d", a), rv0_8, 1'b1);
      chk8($sformatf("init_rd1_a%0d", a), rd1_8, 8'h00);
      chk1($sformatf("init_rv1_a%0d", a), rv1_8, 1'b1);
    end

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].cs, tbl[i].we, tbl[i].wa, tbl[i].wd,
            tbl[i].re0, tbl[i].ra0, tbl[i].re1, tbl[i].ra1);
      step();
      chk8($sformatf("v%0d_rd0", i), rd0_8, tbl[i].rd0);
      chk1($sformatf("v%0d_rv0", i), rv0_8, tbl[i].rv0);
      chk8($sformatf("v%0d_rd1", i), rd1_8, tbl[i].rd1);
      chk1($sformatf("v%0d_rv1", i), rv1_8, tbl[i].rv1);
      chk1($sformatf("v%0d_err", i), err_8, 1'b0);
    end

    // DPTH=6: write to 7 dropped, read of 6 returns 0 with the error pulse.
    drive(1'b1, 1'b1, 3'd7, 8'hEE, 1'b0, 3'd0, 1'b1, 3'd6);
    step();
    chk8("d6_oor_rd1", rd1_6, 8'h00);
    chk1("d6_oor_rv1", rv1_6, 1'b1);
    chk1("d6_oor_err", err_6, 1'b1);
    idle_in();
    step();
    chk1("d6_err_pulse", err_6, 1'b0);
    chk1("d6_rv1_pulse", rv1_6, 1'b0);
    chk8("d6_rd1_hold", rd1_6, 8'h00);
    drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 3'd5);
    step();
    chk8("d6_keep_a3", rd0_6, 8'hA5);
    chk8("d6_keep_a5", rd1_6, 8'h77);
    chk1("d6_inrange_err", err_6, 1'b0);
    drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 1'b0, 3'd0);
    step();
    chk8("d6_oor_rd0", rd0_6, 8'h00);
    chk1("d6_oor_rv0", rv0_6, 1'b1);
    chk1("d6_oor_err0", err_6, 1'b1);
    drive(1'b1, 1'b1, 3'd6, 8'h12, 1'b1, 3'd5, 1'b0, 3'd0);
    step();
    chk1("d6_wr_oor_err", err_6, 1'b1);
    chk8("d6_wr_oor_rd0", rd0_6, 8'h77);

    for (int a = 0; a < 8; a++) begin
      drive(1'b1, 1'b1, 3'(a), 8'(8'h10 + a), 1'b0, 3'd0, 1'b0, 3'd0);
      step();
    end
    drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 1'b1, 3'd7);
    step();
    chk8("fill_a4", rd0_8, 8'h14);
    chk8("fill_a7", rd1_8, 8'h17);

    drive(1'b1, 1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 1'b0, 3'd0);
    Clr = 1'b1;
    step();
    chk1("clr_busy", busy_8, 1'b1);
    drive(1'b1, 1'b1, 3'd1, 8'hEE, 1'b1, 3'd1, 1'b1, 3'd1);
    wait_clear(1'b0, t8, t6, quiet);
    chki("clr_busy_len", t8, 8);
    chk1("clr_ignored_reqs", quiet, 1'b1);
    idle_in();
    for (int a = 0; a < 8; a++) begin
      drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'(a), 1'b1, 3'(a));
      step();
      chk8($sformatf("clr_rd0_a%0d", a), rd0_8, 8'h00);
      chk8($sformatf("clr_rd1_a%0d", a), rd1_8, 8'h00);
    end

    drive(1'b1, 1'b1, 3'd6, 8'h3C, 1'b0, 3'd0, 1'b0, 3'd0);
    step();
    drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 1'b0, 3'd0);
    step();
    chk8("pre_rst_a6", rd0_8, 8'h3C);
    idle_in();
    Clr = 1'b1;
    step();
    Clr = 1'b0;
    repeat (4) step();
    Rst_n = 1'b0;
    #2;
    chk1("mid_rst_busy8", busy_8, 1'b1);
    chk1("mid_rst_busy6", busy_6, 1'b1);
    chk8("mid_rst_rd0", rd0_8, 8'h00);
    chk1("mid_rst_rv0", rv0_8, 1'b0);
    chk1("mid_rst_err", err_8, 1'b0);
    #2 Rst_n = 1'b1;
    wait_clear(1'b1, t8, t6, quiet);
    chki("mid_rst_len8", t8, 8);
    chki("mid_rst_len6", t6, 6);
    drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 1'b1, 3'd3);
    step();
    chk8("post_rst_a6", rd0_8, 8'h00);
    chk1("post_rst_rv0", rv0_8, 1'b1);
    chk8("post_rst_a3", rd1_8, 8'h00);
    idle_in();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
